// File: rtl/message_splitter.sv
// rtl/message_splitter.sv - emits a MSG_BITS message as 32-bit a/b word pairs, most significant pair first.
// Optional build macro MESSAGE_SPLITTER_BYTESWAP_EN byte-reverses a and b for a little-endian host.
module message_splitter #(
  parameter  int MSG_BITS = 512,
  localparam int PAIRS    = MSG_BITS / 64,
  localparam int IDX_W    = $clog2(PAIRS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MSG_BITS-1:0] message,
  input  logic                next,
  output logic [31:0]         a,
  output logic [31:0]         b,
  output logic                valid,
  output logic [IDX_W-1:0]    index,
  output logic                done
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [MSG_BITS-1:0] r_shift;
  logic [IDX_W-1:0]    r_cnt;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic                r_valid;
  logic                r_done;
  logic                w_advance;
  logic                w_last;

  function automatic logic [31:0] host_word(input logic [31:0] w);
`ifdef MESSAGE_SPLITTER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Load wins over next; the old message is dropped without a done pulse.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_last       = 1'b0;
    if (load) begin
      w_state_next = S_SEND;
    end else if (r_state == S_SEND && next) begin
      if (r_cnt == IDX_W'(PAIRS - 1)) begin
        w_state_next = S_IDLE;
        w_last       = 1'b1;
      end else begin
        w_advance = 1'b1;
      end
    end
  end

  // The current pair always sits at the top of r_shift; a/b are registered copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (load) begin
        r_shift <= message;
        r_cnt   <= '0;
        r_a     <= host_word(message[MSG_BITS-1 -: 32]);
        r_b     <= host_word(message[MSG_BITS-33 -: 32]);
        r_valid <= 1'b1;
      end else if (w_advance) begin
        r_shift <= r_shift << 64;
        r_cnt   <= r_cnt + IDX_W'(1);
        r_a     <= host_word(r_shift[MSG_BITS-65 -: 32]);
        r_b     <= host_word(r_shift[MSG_BITS-97 -: 32]);
      end else if (w_last) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign a     = r_a;
  assign b     = r_b;
  assign valid = r_valid;
  assign index = r_cnt;
  assign done  = r_done;

endmodule

// File: tb/tb_message_splitter.sv
// tb/tb_message_splitter.sv - scoreboard bench for message_splitter with a pair-queue reference model.
module tb_message_splitter;
  localparam int MSG_BITS = 512;
  localparam int PAIRS    = MSG_BITS / 64;
  localparam int IDX_W    = $clog2(PAIRS);
  localparam int WORDS    = MSG_BITS / 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                load;
  logic                next;
  logic [MSG_BITS-1:0] message;
  logic [31:0]         a;
  logic [31:0]         b;
  logic                valid;
  logic [IDX_W-1:0]    index;
  logic                done;

  message_splitter #(.MSG_BITS(MSG_BITS)) dut (
    .clk(clk), .reset(reset), .load(load), .message(message), .next(next),
    .a(a), .b(b), .valid(valid), .index(index), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wb;
  } pair_t;

  pair_t       exp_q[$];
  pair_t       pend_q[$];
  bit          exp_valid = 1'b0;
  bit          exp_done  = 1'b0;
  logic [31:0] words[WORDS];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] host(input logic [31:0] w);
`ifdef MESSAGE_SPLITTER_BYTESWAP_EN
    logic [31:0] r;
    r = {<<8{w}};
    return r;
`else
    return w;
`endif
  endfunction

  // Message is the words concatenated top-down; pair k is words 2k and 2k+1.
  task automatic load_words();
    pair_t p;
    pend_q.delete();
    for (int i = 0; i < WORDS; i++) message[MSG_BITS-1-32*i -: 32] = words[i];
    for (int k = 0; k < PAIRS; k++) begin
      p.wa = words[2*k];
      p.wb = words[2*k+1];
      pend_q.push_back(p);
    end
  endtask

  task automatic rand_words();
    for (int i = 0; i < WORDS; i++) words[i] = $urandom;
  endtask

  task automatic step(input bit l, input bit n);
    load = l;
    next = n;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_a", 64'(a), 64'd0);
      chk("rst_b", 64'(b), 64'd0);
      chk("rst_index", 64'(index), 64'd0);
      exp_q.delete();
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end else begin
      chk("valid", 64'(valid), 64'(exp_valid));
      chk("done", 64'(done), 64'(exp_done));
      if (exp_valid) begin
        chk("a", 64'(a), 64'(host(exp_q[0].wa)));
        chk("b", 64'(b), 64'(host(exp_q[0].wb)));
        chk("index", 64'(index), 64'(PAIRS - exp_q.size()));
      end
      exp_done = 1'b0;
      if (load) begin
        exp_q     = pend_q;
        exp_valid = 1'b1;
      end else if (next && exp_valid) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          exp_valid = 1'b0;
          exp_done  = 1'b1;
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    next    = 1'b0;
    message = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Incrementing words, hold, drain back-to-back, then next in IDLE
    for (int i = 0; i < WORDS; i++) words[i] = 32'(i + 1);
    load_words();
    step(1'b1, 1'b0);
    chk("first_a", 64'(a), 64'(host(32'h1)));
    chk("first_b", 64'(b), 64'(host(32'h2)));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (PAIRS) step(1'b0, 1'b1);
    chk("done_pulse", 64'(done), 64'd1);
    repeat (3) step(1'b0, 1'b1);

    // Load together with next at index 5
    rand_words();
    load_words();
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    rand_words();
    load_words();
    step(1'b1, 1'b1);
    chk("reload_index", 64'(index), 64'd0);
    repeat (PAIRS + 2) step(1'b0, 1'b1);

    // Asynchronous reset between edges at index 3
    rand_words();
    load_words();
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_valid", 64'(valid), 64'd0);
    chk("async_a", 64'(a), 64'd0);
    chk("async_b", 64'(b), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Known pair for the byte order check
    rand_words();
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    load_words();
    step(1'b1, 1'b0);
`ifdef MESSAGE_SPLITTER_BYTESWAP_EN
    chk("swap_a", 64'(a), 64'h44332211);
    chk("swap_b", 64'(b), 64'h88776655);
`else
    chk("plain_a", 64'(a), 64'h11223344);
    chk("plain_b", 64'(b), 64'h55667788);
`endif
    repeat (PAIRS + 1) step(1'b0, 1'b1);

    // Random traffic with occasional reloads
    repeat (40) begin
      rand_words();
      load_words();
      step(1'b1, 1'($urandom % 2));
      repeat ($urandom_range(5, 25)) begin
        if ($urandom % 16 == 0) begin
          rand_words();
          load_words();
          step(1'b1, 1'($urandom % 2));
        end else begin
          step(1'b0, ($urandom % 4) != 0);
        end
      end
    end

    repeat (3) step(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
